// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
package regfile_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RW   = $clog2(NREG);

  localparam logic [RW-1:0] REG_ZERO = 5'd0;

  // One write-back request as presented by a producer.
  typedef struct packed {
    logic            valid;
    logic [RW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wb_req_t;

  // Which requester won the most recent transfer.
  typedef enum logic {
    RR_ALU = 1'b0,
    RR_LSU = 1'b1
  } rr_sel_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle between the ALU/LSU/decode producers and the write-back arbiter.
interface regfile_wb_if;
  import regfile_pkg::*;

  logic            alu_valid;
  logic [RW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;

  logic            lsu_valid;
  logic [RW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;

  logic            iss_valid;
  logic [RW-1:0]   iss_rd;

  logic            rf_we;
  logic [RW-1:0]   rf_wa;
  logic [XLEN-1:0] rf_wdata;
  logic [NREG-1:0] busy;

  // Producer / decode / register-file side.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    output iss_valid, iss_rd,
    input  alu_ready, lsu_ready,
    input  rf_we, rf_wa, rf_wdata, busy
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    input  iss_valid, iss_rd,
    output alu_ready, lsu_ready,
    output rf_we, rf_wa, rf_wdata, busy
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 is the ALU, bit 1 the LSU.
module rr_arb2
  import regfile_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] grant_o
);

  rr_sel_e rr_last_q;

  // Grant the lone requester, or on a tie the one that did not win last.
  // Nothing is granted while reset is held.
  always_comb begin
    grant_o = 2'b00;
    if (rst) begin
      case (req_i)
        2'b01:   grant_o = 2'b01;
        2'b10:   grant_o = 2'b10;
        2'b11:   grant_o = (rr_last_q == RR_LSU) ? 2'b01 : 2'b10;
        default: grant_o = 2'b00;
      endcase
    end
  end

  // Remember the winner of every transfer; reset favours the ALU next.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_last_q <= RR_LSU;
    end else if (grant_o[0]) begin
      rr_last_q <= RR_ALU;
    end else if (grant_o[1]) begin
      rr_last_q <= RR_LSU;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter: picks ALU or LSU result for the single regfile write
// port, registers the port, drops x0 writes and tracks pending destinations.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  regfile_wb_if.slave  wb
);

  wb_req_t         alu_req;
  wb_req_t         lsu_req;
  logic [1:0]      grant;
  logic            xfer;
  logic [RW-1:0]   win_rd;
  logic [XLEN-1:0] win_data;
  logic            rf_we_d;

  logic            rf_we_q;
  logic [RW-1:0]   rf_wa_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic [NREG-1:0] busy_vec;

  assign alu_req = {wb.alu_valid, wb.alu_rd, wb.alu_data};
  assign lsu_req = {wb.lsu_valid, wb.lsu_rd, wb.lsu_data};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_i   ({lsu_req.valid, alu_req.valid}),
    .grant_o (grant)
  );

  assign wb.alu_ready = grant[0];
  assign wb.lsu_ready = grant[1];

  // Grant is only ever given to a valid requester, so any grant is a transfer.
  assign xfer     = |grant;
  assign win_rd   = grant[1] ? lsu_req.rd   : alu_req.rd;
  assign win_data = grant[1] ? lsu_req.data : alu_req.data;

  // x0 transfers are consumed but never reach the register file.
  assign rf_we_d = xfer && (win_rd != REG_ZERO);

  // Registered write port; address/data hold when no write happens.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we_q    <= 1'b0;
      rf_wa_q    <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q <= rf_we_d;
      if (rf_we_d) begin
        rf_wa_q    <= win_rd;
        rf_wdata_q <= win_data;
      end
    end
  end

  assign busy_vec[0] = 1'b0;

  // One busy flop per architectural register except x0.
  generate
    for (genvar gi = 1; gi < NREG; gi++) begin : g_busy
      logic set_d;
      logic clr_d;
      logic busy_q;

      assign set_d = wb.iss_valid && (wb.iss_rd == RW'(gi));
      assign clr_d = xfer && (win_rd == RW'(gi));

      // A new issue beats a completing write: a younger producer is in flight.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          busy_q <= 1'b0;
        end else if (set_d) begin
          busy_q <= 1'b1;
        end else if (clr_d) begin
          busy_q <= 1'b0;
        end
      end

      assign busy_vec[gi] = busy_q;
    end
  endgenerate

  assign wb.rf_we    = rf_we_q;
  assign wb.rf_wa    = rf_wa_q;
  assign wb.rf_wdata = rf_wdata_q;
  assign wb.busy     = busy_vec;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for the write-back arbiter: vector table plus reset corner sequences.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        iv;
    logic [4:0]  ird;
    logic        exp_ar;
    logic        exp_lr;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [31:0] busy_m;
  exp_t q[$];
  vec_t tbl[19];

  regfile_wb_if bus ();

  regfile_wb_arbiter dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic iv, input logic [4:0] ird,
                              input logic ar, input logic lr);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird;
    v.exp_ar = ar; v.exp_lr = lr;
    return v;
  endfunction

  // Entered just after a rising edge; leaves just after the next one.
  task automatic step(input vec_t v, input int idx);
    exp_t e;
    logic [31:0] nxt;
    bus.alu_valid = v.av; bus.alu_rd = v.ard; bus.alu_data = v.ad;
    bus.lsu_valid = v.lv; bus.lsu_rd = v.lrd; bus.lsu_data = v.ld;
    bus.iss_valid = v.iv; bus.iss_rd = v.ird;
    #3;
    chk($sformatf("alu_ready[%0d]", idx), 64'(bus.alu_ready), 64'(v.exp_ar));
    chk($sformatf("lsu_ready[%0d]", idx), 64'(bus.lsu_ready), 64'(v.exp_lr));
    chk($sformatf("busy[%0d]", idx), 64'(bus.busy), 64'(busy_m));
    e.we = 1'b0; e.wa = '0; e.data = '0;
    if (v.exp_ar && v.ard != 5'd0) begin
      e.we = 1'b1; e.wa = v.ard; e.data = v.ad;
    end else if (v.exp_lr && v.lrd != 5'd0) begin
      e.we = 1'b1; e.wa = v.lrd; e.data = v.ld;
    end
    q.push_back(e);
    nxt = busy_m;
    if (v.exp_ar) nxt[v.ard] = 1'b0;
    if (v.exp_lr) nxt[v.lrd] = 1'b0;
    if (v.iv && v.ird != 5'd0) nxt[v.ird] = 1'b1;
    nxt[0] = 1'b0;
    busy_m = nxt;
    @(posedge clk);
    #1;
    e = q.pop_front();
    $display("txn %0d: ar=%0b lr=%0b rf_we=%0b rf_wa=%0d rf_wdata=%08h busy=%08h",
             idx, v.exp_ar, v.exp_lr, bus.rf_we, bus.rf_wa, bus.rf_wdata, bus.busy);
    chk($sformatf("rf_we[%0d]", idx), 64'(bus.rf_we), 64'(e.we));
    if (e.we) begin
      chk($sformatf("rf_wa[%0d]", idx), 64'(bus.rf_wa), 64'(e.wa));
      chk($sformatf("rf_wdata[%0d]", idx), 64'(bus.rf_wdata), 64'(e.data));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    busy_m = '0;

    // Arbitration state after reset: rr_last = LSU, so the ALU wins the first tie.
    tbl[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  32'h0,    0, 0, 1, 0);
    tbl[1]  = mk(0, 0,  32'h0,        0, 0,  32'h0,    0, 0, 0, 0);
    tbl[2]  = mk(0, 0,  32'h0,        1, 3,  32'h33,   0, 0, 0, 1);
    tbl[3]  = mk(1, 1,  32'h11,       1, 9,  32'h99,   0, 0, 1, 0);
    tbl[4]  = mk(1, 2,  32'h22,       1, 9,  32'h99,   0, 0, 0, 1);
    tbl[5]  = mk(1, 2,  32'h22,       1, 10, 32'hAA,   0, 0, 1, 0);
    tbl[6]  = mk(1, 3,  32'h33,       1, 10, 32'hAA,   0, 0, 0, 1);
    tbl[7]  = mk(1, 3,  32'h33,       0, 0,  32'h0,    0, 0, 1, 0);
    tbl[8]  = mk(0, 0,  32'h0,        1, 0,  32'h1234, 0, 0, 0, 1);
    tbl[9]  = mk(1, 4,  32'h44,       1, 11, 32'hBB,   0, 0, 1, 0);
    tbl[10] = mk(0, 0,  32'h0,        1, 11, 32'hBB,   0, 0, 0, 1);
    tbl[11] = mk(0, 0,  32'h0,        0, 0,  32'h0,    1, 7, 0, 0);
    tbl[12] = mk(1, 7,  32'h77,       0, 0,  32'h0,    0, 0, 1, 0);
    tbl[13] = mk(0, 0,  32'h0,        0, 0,  32'h0,    1, 7, 0, 0);
    tbl[14] = mk(1, 7,  32'h78,       0, 0,  32'h0,    1, 7, 1, 0);
    tbl[15] = mk(0, 0,  32'h0,        1, 7,  32'h79,   0, 0, 0, 1);
    tbl[16] = mk(0, 0,  32'h0,        0, 0,  32'h0,    1, 0, 0, 0);
    tbl[17] = mk(1, 20, 32'h20,       0, 0,  32'h0,    0, 0, 1, 0);
    tbl[18] = mk(0, 0,  32'h0,        0, 0,  32'h0,    0, 0, 0, 0);

    // Reset held with an ALU request pending: nothing is accepted or written.
    rst = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    bus.lsu_valid = 1'b0; bus.lsu_rd = '0;   bus.lsu_data = '0;
    bus.iss_valid = 1'b0; bus.iss_rd = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    chk("rst_rf_we", 64'(bus.rf_we), 64'd0);
    chk("rst_rf_wa", 64'(bus.rf_wa), 64'd0);
    chk("rst_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      step(tbl[i], i);
    end

    // Build up busy = 0x0F00, then reset asynchronously mid-burst.
    for (int i = 0; i < 4; i++) begin
      step(mk(0, 0, 32'h0, 0, 0, 32'h0, 1, 5'(8 + i), 0, 0), 100 + i);
    end
    step(mk(1, 1, 32'hC1, 1, 2, 32'hC2, 0, 0, 0, 1), 104);
    chk("pre_busy", 64'(bus.busy), 64'h0F00);
    chk("pre_rf_we", 64'(bus.rf_we), 64'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_busy", 64'(bus.busy), 64'd0);
    chk("async_rf_we", 64'(bus.rf_we), 64'd0);
    chk("async_rf_wa", 64'(bus.rf_wa), 64'd0);
    chk("async_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("async_alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("async_lsu_ready", 64'(bus.lsu_ready), 64'd0);
    bus.alu_valid = 1'b0;
    bus.lsu_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    busy_m = '0;
    q.delete();

    // After reset the ALU again wins the first tie.
    step(mk(1, 6, 32'h66, 1, 13, 32'hDD, 0, 0, 1, 0), 200);
    step(mk(0, 0, 32'h0,  1, 13, 32'hDD, 0, 0, 0, 1), 201);
    step(mk(0, 0, 32'h0,  0, 0,  32'h0,  0, 0, 0, 0), 202);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
